control_sequencer: RTL

// - Fetch/decode/execute controller for the 8-bit accumulator CPU; drives the ALU as its initiator.
// - Owns PC, IR, AC and DR. Issues memory requests and supplies AC, DR and the ALU selector.
// - Commits the ALU result back into AC.
// - Sits between the instruction/data memory and the combinational ALU.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/instr_decoder.sv | 48 ++++
 rtl/control_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit accumulator CPU: opcodes, ALU selectors,
// controller state encoding and the decoded-instruction record.
package cpu_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_ADDR_W = 5;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_CMA = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_DBL = 3'b011;
    localparam logic [2:0] ALU_CMP = 3'b110;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    typedef struct packed {
        logic       needs_read;
        logic       is_store;
        logic       is_halt;
        logic       is_load;
        logic       uses_alu;
        logic [2:0] alu_sel;
    } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode: which memory phase an instruction needs and
// which ALU operation its EXEC cycle uses.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [2:0] opcode,
    output decode_t    dec
);

    always_comb begin
        dec         = '0;
        dec.alu_sel = ALU_ADD;
        case (opcode)
            OP_ADD: begin
                dec.needs_read = 1'b1;
                dec.uses_alu   = 1'b1;
                dec.alu_sel    = ALU_ADD;
            end
            OP_SUB: begin
                dec.needs_read = 1'b1;
                dec.uses_alu   = 1'b1;
                dec.alu_sel    = ALU_SUB;
            end
            OP_XOR: begin
                dec.needs_read = 1'b1;
                dec.uses_alu   = 1'b1;
                dec.alu_sel    = ALU_XOR;
            end
            OP_SHL: begin
                dec.uses_alu = 1'b1;
                dec.alu_sel  = ALU_DBL;
            end
            // LDA reads memory but bypasses the ALU, so it leaves alu_sel alone.
            OP_LDA: begin
                dec.needs_read = 1'b1;
                dec.is_load    = 1'b1;
            end
            OP_STA: dec.is_store = 1'b1;
            OP_CMA: begin
                dec.uses_alu = 1'b1;
                dec.alu_sel  = ALU_CMP;
            end
            OP_HLT: dec.is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute controller for the accumulator CPU. Owns PC, IR, AC
// and DR, runs the memory handshake and commits the external ALU's result.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [2:0]        alu_sel,
    output logic [DATA_W-1:0] alu_ac,
    output logic [DATA_W-1:0] alu_dr,
    input  logic [DATA_W-1:0] alu_result,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic [DATA_W-1:0] dr_q, dr_d;
    logic [2:0]        alu_sel_q, alu_sel_d;
    logic              ack;
    decode_t           dec;

    instr_decoder u_decoder (
        .opcode (ir_q[DATA_W-1 -: 3]),
        .dec    (dec)
    );

    // Bus outputs depend only on registered state, so they never glitch on inputs.
    assign mem_req   = (state_q == S_FETCH) || (state_q == S_READ) || (state_q == S_WRITE);
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = (state_q == S_FETCH) ? pc_q :
                       (state_q == S_READ || state_q == S_WRITE) ? ir_q[ADDR_W-1:0] : '0;
    assign mem_wdata = (state_q == S_WRITE) ? ac_q : '0;
    assign ack       = mem_ack && mem_req;

    assign alu_sel = alu_sel_q;
    assign alu_ac  = ac_q;
    assign alu_dr  = dr_q;
    assign halted  = (state_q == S_HALT);
    assign pc      = pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ac_d      = ac_q;
        dr_d      = dr_q;
        alu_sel_d = alu_sel_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec.is_halt)         state_d = S_HALT;
                else if (dec.is_store)   state_d = S_WRITE;
                else if (dec.needs_read) state_d = S_READ;
                else                     state_d = S_EXEC;
                if (!dec.needs_read && dec.uses_alu) alu_sel_d = dec.alu_sel;
            end
            S_READ: begin
                if (ack) begin
                    dr_d    = mem_rdata;
                    state_d = S_EXEC;
                    if (dec.uses_alu) alu_sel_d = dec.alu_sel;
                end
            end
            S_EXEC: begin
                ac_d    = dec.is_load ? dr_q : alu_result;
                state_d = S_FETCH;
            end
            S_WRITE: begin
                if (ack) state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            ac_q      <= '0;
            dr_q      <= '0;
            alu_sel_q <= ALU_ADD;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            ac_q      <= ac_d;
            dr_q      <= dr_d;
            alu_sel_q <= alu_sel_d;
        end
    end

endmodule
